gat_load_ctrl: RTL
==================

GAT_LOAD_CTRL -- requirements
Module: gat_load_ctrl

Interface
REQ-001 SHALL have parameter TOP_WIDTH, default 32, meaning host data bus width.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of BRAM load channels.
REQ-003 SHALL have parameter WADDR_W, default 18, meaning BRAM word-address width.
REQ-004 SHALL have parameter CNT_W, default 20, meaning per-channel write-counter width.
REQ-005 SHALL have a single clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, meaning sole clock.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, meaning begin load session (level sampled per cycle).
REQ-009 SHALL have port exp_cnt, input, NUM_CH*CNT_W, meaning expected words per channel (channel i at bits [i*CNT_W +: CNT_W]).
REQ-010 SHALL have port host_ena, input, NUM_CH, meaning per-channel write enable.
REQ-011 SHALL have port host_wea, input, NUM_CH, meaning per-channel write strobe.
REQ-012 SHALL have port host_addr, input, WADDR_W+2, meaning byte address.
REQ-013 SHALL have port host_din, input, TOP_WIDTH, meaning write data.
REQ-014 SHALL have port bram_we, output, NUM_CH, meaning registered BRAM write enable.
REQ-015 SHALL have port bram_addr, output, WADDR_W, meaning registered word address.
REQ-016 SHALL have port bram_din, output, TOP_WIDTH, meaning registered write data.
REQ-017 SHALL have port load_done, output, NUM_CH, meaning sticky per-channel complete flags.
REQ-018 SHALL have port core_start, output, 1, meaning one-cycle start pulse to the GAT core.
REQ-019 SHALL have port core_done, input, 1, meaning GAT core finished.
REQ-020 SHALL have port gat_ready, output, 1, meaning results are valid.
REQ-021 SHALL have port err, output, 3, meaning sticky flags: bit0 overrun, bit1 collision, bit2 write-outside-LOAD.
REQ-022 SHALL have port dbg_cycles, output, TOP_WIDTH, meaning RUN-cycle count, saturating.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD, ARM, RUN, DONE.
REQ-024 In IDLE, start=1 SHALL transition to LOAD and clear counters, load_done, err and dbg_cycles.
REQ-025 In LOAD, a write SHALL be a cycle with host_ena[i]&host_wea[i].
REQ-026 An accepted write SHALL drive bram_we one-hot at bit i, bram_addr=host_addr[WADDR_W+1:2] and bram_din=host_din exactly 1 cycle later; host_addr[1:0] SHALL be ignored.
REQ-027 Each accepted write SHALL increment cnt[i]; load_done[i] SHALL set in the cycle after cnt[i] reaches exp_cnt[i].
REQ-028 A channel with exp_cnt[i]=0 SHALL set load_done[i] one cycle after entering LOAD.
REQ-029 A write to channel i with load_done[i]=1 SHALL be dropped (bram_we stays 0) and SHALL set err[0].
REQ-030 When more than one channel writes in the same cycle, the lowest index SHALL be accepted, the others dropped, and err[1] set.
REQ-031 When all load_done bits are 1, the FSM SHALL go LOAD->ARM; ARM SHALL assert core_start for exactly 1 cycle, then go to RUN.
REQ-032 In RUN, dbg_cycles SHALL increment each cycle, saturating at all-ones; core_done=1 SHALL go to DONE with gat_ready=1 from the next cycle.
REQ-033 Writes in IDLE, ARM, RUN or DONE SHALL be dropped and SHALL set err[2].
REQ-034 In DONE, start=1 SHALL go to LOAD and clear gat_ready, counters, load_done, err and dbg_cycles.
REQ-035 start SHALL be ignored in LOAD, ARM and RUN.
REQ-036 core_done SHALL be ignored outside RUN.

Reset
REQ-037 rst=1 SHALL force IDLE on the next edge from any state, including mid-LOAD and mid-RUN.
REQ-038 Reset SHALL zero bram_we, bram_addr, bram_din, load_done, core_start, gat_ready, err, dbg_cycles and all counters.
REQ-039 A write presented during reset SHALL not reach bram_we.

Verification
REQ-040 Stimulus: NUM_CH=4, exp_cnt={3,2,0,1}, start, then sequential writes. Required response: each bram_we 1 cycle after its write with addr = byte addr >> 2; load_done=4'b1111 after the last write; single core_start pulse 2 cycles later.
REQ-041 Stimulus: 4th write on channel 0 with exp_cnt[0]=3. Required response: bram_we[0] stays 0 and err=3'b001.
REQ-042 Stimulus: simultaneous writes on channels 1 and 3. Required response: bram_we=4'b0010 and err[1]=1; channel 3 count unchanged.
REQ-043 Stimulus: in RUN for 10 cycles, then core_done. Required response: dbg_cycles=10 and gat_ready=1; a following write sets err[2] and produces no bram_we.
REQ-044 Stimulus: rst asserted mid-LOAD after 1 of 3 writes. Required response: all outputs 0 and state IDLE; after restart, 3 further writes are needed to complete the channel.
REQ-045 Stimulus: start in DONE. Required response: gat_ready falls and the session reloads cleanly with a second core_start.

Source files
------------

// File: rtl/gat_load_if.sv
// Host write bus into the loader and registered BRAM write bus out of it.
interface gat_load_if #(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int WADDR_W   = 18
);
  logic [NUM_CH-1:0]    host_ena;
  logic [NUM_CH-1:0]    host_wea;
  logic [WADDR_W+1:0]   host_addr;
  logic [TOP_WIDTH-1:0] host_din;
  logic [NUM_CH-1:0]    bram_we;
  logic [WADDR_W-1:0]   bram_addr;
  logic [TOP_WIDTH-1:0] bram_din;

  modport master (
    output host_ena, host_wea, host_addr, host_din,
    input  bram_we, bram_addr, bram_din
  );

  modport slave (
    input  host_ena, host_wea, host_addr, host_din,
    output bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/gat_load_ctrl.sv
// Loads per-channel BRAMs from a host bus, then launches the GAT core and
// tracks its run until done.
module gat_load_ctrl #(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int WADDR_W   = 18,
  parameter int CNT_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH*CNT_W-1:0] exp_cnt,
  input  logic                    core_done,
  output logic [NUM_CH-1:0]       load_done,
  output logic                    core_start,
  output logic                    gat_ready,
  output logic [2:0]              err,
  output logic [TOP_WIDTH-1:0]    dbg_cycles,
  gat_load_if.slave               bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [TOP_WIDTH-1:0] sat_inc(input logic [TOP_WIDTH-1:0] v);
    return (&v) ? v : v + {{(TOP_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]             load_done_q, load_done_d;
  logic [NUM_CH-1:0]             bram_we_q, bram_we_d;
  logic [WADDR_W-1:0]            bram_addr_q, bram_addr_d;
  logic [TOP_WIDTH-1:0]          bram_din_q, bram_din_d;
  logic                          core_start_q, core_start_d;
  logic                          gat_ready_q, gat_ready_d;
  logic [2:0]                    err_q, err_d;
  logic [TOP_WIDTH-1:0]          dbg_cycles_q, dbg_cycles_d;

  logic [NUM_CH-1:0] wr_vec, sel_oh, ch_full, cnt_hit, accept_oh;
  logic              collision, overrun, session_start;
  logic              unused_addr_lsb;

  // Byte-lane bits of the host address carry no meaning for word-wide BRAMs.
  assign unused_addr_lsb = ^bus.host_addr[1:0];

  // A channel counts as full as soon as its count hits the target, so a write
  // landing in the cycle before load_done rises is still caught as an overrun.
  always_comb begin
    wr_vec  = bus.host_ena & bus.host_wea;
    sel_oh  = wr_vec & (~wr_vec + {{(NUM_CH-1){1'b0}}, 1'b1});
    cnt_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_hit[i] = (cnt_q[i] == exp_cnt[i*CNT_W +: CNT_W]);
    end
    ch_full       = load_done_q | cnt_hit;
    accept_oh     = sel_oh & ~ch_full;
    collision     = |(wr_vec & ~sel_oh);
    overrun       = |(sel_oh & ch_full);
    session_start = start && (state_q == S_IDLE || state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      load_done_q  <= '0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      core_start_q <= 1'b0;
      gat_ready_q  <= 1'b0;
      err_q        <= '0;
      dbg_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_done_q  <= load_done_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_din_q   <= bram_din_d;
      core_start_q <= core_start_d;
      gat_ready_q  <= gat_ready_d;
      err_q        <= err_d;
      dbg_cycles_q <= dbg_cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (&load_done_q) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (core_done) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    load_done_d  = load_done_q;
    bram_we_d    = '0;
    bram_addr_d  = bram_addr_q;
    bram_din_d   = bram_din_q;
    core_start_d = 1'b0;
    gat_ready_d  = gat_ready_q;
    err_d        = err_q;
    dbg_cycles_d = dbg_cycles_q;
    if (session_start) begin
      cnt_d        = '0;
      load_done_d  = '0;
      gat_ready_d  = 1'b0;
      err_d        = '0;
      dbg_cycles_d = '0;
    end else if (state_q == S_LOAD) begin
      load_done_d = load_done_q | cnt_hit;
      if (|accept_oh) begin
        bram_we_d   = accept_oh;
        bram_addr_d = bus.host_addr[WADDR_W+1:2];
        bram_din_d  = bus.host_din;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_oh[i]) cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
      err_d[0] = err_q[0] | overrun;
      err_d[1] = err_q[1] | collision;
    end else begin
      if (|wr_vec) err_d[2] = 1'b1;
      if (state_q == S_ARM) core_start_d = 1'b1;
      if (state_q == S_RUN) begin
        dbg_cycles_d = sat_inc(dbg_cycles_q);
        if (core_done) gat_ready_d = 1'b1;
      end
    end
  end

  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;
  assign load_done     = load_done_q;
  assign core_start    = core_start_q;
  assign gat_ready     = gat_ready_q;
  assign err           = err_q;
  assign dbg_cycles    = dbg_cycles_q;

endmodule
